mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache FSM (line load and write-back).
- Grants one requester at a time and runs a BEATS-word line burst to memory. Holds the grant until the burst completes, then signals completion to the owner.
- Sits between both cache controllers and the memory interface. The cache FSMs keep their stall asserted until they see their done pulse.

Parameters:
- AW, 32, address width in bits
- DW, 32, data word width in bits
- BEATS, 4, words per cache line. Must be a power of two and at least 1.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- ic_req  in  1  I-cache line read request; held until ic_done
- ic_addr  in  AW  I-cache line address
- ic_rdata  out  DW  read beat data to I-cache
- ic_rvalid  out  1  ic_rdata valid this cycle
- ic_done  out  1  one-cycle pulse: I-cache transaction complete
- dc_req  in  1  D-cache request; held until dc_done
- dc_we  in  1  1 = write-back burst, 0 = line load
- dc_addr  in  AW  D-cache line address
- dc_wdata  in  DW  write-back word selected by beat_idx
- dc_rdata  out  DW  read beat data to D-cache
- dc_rvalid  out  1  dc_rdata valid this cycle
- dc_done  out  1  one-cycle pulse: D-cache transaction complete
- beat_idx  out  log2(BEATS) (min 1)  current beat of the active burst
- mem_req  out  1  memory access request for the current beat
- mem_we  out  1  memory write enable
- mem_addr  out  AW  word address of the current beat
- mem_wdata  out  DW  write data (dc_wdata passed through)
- mem_rdata  in  DW  memory read data
- mem_ack  in  1  current beat accepted/completed this cycle

Behaviour:
- Reset values: state=IDLE, owner=none, beat_idx=0, and every output 0.
- States:
  - IDLE: sample requests. If any request is present, latch owner, base address and we, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: mem_req=1 and mem_we=latched we (DC only; IC is always a read). mem_addr = base + beat_idx*(DW/8).
    - On mem_ack: reads drive the owner's rvalid=1 combinationally in that cycle, with rdata=mem_rdata. beat_idx increments.
    - On mem_ack with beat_idx==BEATS-1: go to DONE and clear beat_idx.
    - Without mem_ack: hold all mem_* outputs stable. No timeout.
  - DONE: owner's done=1 for exactly one cycle, mem_req=0, then IDLE.
- Base address: the latched address with its low log2(BEATS)+log2(DW/8) bits forced to 0.
- Latency:
  - Request seen in IDLE at cycle N gives mem_req=1 at cycle N+1.
  - done is asserted the cycle after the final ack.
  - Minimum 1 IDLE cycle between transactions.
  - With mem_ack held high, a burst takes BEATS+2 cycles from the request.
- Arbitration, simultaneous ic_req and dc_req in IDLE: DC wins (see optional feature).
- Requests arriving during BUSY/DONE are ignored until the next IDLE.
- A requester that deasserts req or changes addr mid-burst has no effect; the burst completes with latched values and done still pulses.
- A requester must deassert req in the cycle after it sees done, or it is regranted.
- mem_wdata = dc_wdata whenever owner is DC, else 0. rdata outputs are 0 when rvalid=0.
- Never asserts both rvalids or both dones in one cycle.
- RST at any point, including mid-burst: next edge returns all state to reset values. mem_req drops to 0, no done pulse is issued, and the partial burst is abandoned.

Optional Feature:
- Macro: MEM_ARB_RR_EN
- Defined: round-robin arbitration. A last_owner register (reset = IC, so DC wins the first tie) updates on each grant. On simultaneous requests, the requester not granted last wins. Uncontended requests are granted immediately regardless of last_owner.
- Not defined: fixed priority, DC always wins ties, and no last_owner register exists.

Test Plan:
- IC-only read, BEATS=4, ic_addr=0x0000_1034, mem_ack held 1 -> mem_addr 0x1030, 0x1034, 0x1038, 0x103C on consecutive cycles. 4 ic_rvalid pulses carrying mem_rdata. ic_done a single cycle after the last ack. Total 6 cycles.
- DC write-back, dc_we=1, dc_addr=0x2000, dc_wdata=0xA0+beat_idx -> mem_we=1, mem_wdata sequence 0xA0..0xA3 at 0x2000..0x200C. No dc_rvalid. dc_done one pulse.
- mem_ack asserted every 3rd cycle during an IC burst -> beat_idx and mem_addr change only on ack cycles; mem_* held between acks; 4 ic_rvalid pulses total.
- ic_req and dc_req raised in the same cycle and held through two rounds -> without MEM_ARB_RR_EN: DC, then DC again after IDLE. With the macro: DC, then IC.
- RST asserted in BUSY after 2 acks -> mem_req=0 next cycle, beat_idx=0, no done. A fresh ic_req afterwards starts at beat 0 from the base address.
- dc_req dropped and dc_addr changed after the first ack -> burst completes at the original addresses and dc_done pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between I-cache refill and D-cache load/write-back bursts.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned BEATS = 4
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     ic_req,
  input  logic [AW-1:0]                            ic_addr,
  output logic [DW-1:0]                            ic_rdata,
  output logic                                     ic_rvalid,
  output logic                                     ic_done,
  input  logic                                     dc_req,
  input  logic                                     dc_we,
  input  logic [AW-1:0]                            dc_addr,
  input  logic [DW-1:0]                            dc_wdata,
  output logic [DW-1:0]                            dc_rdata,
  output logic                                     dc_rvalid,
  output logic                                     dc_done,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] beat_idx,
  output logic                                     mem_req,
  output logic                                     mem_we,
  output logic [AW-1:0]                            mem_addr,
  output logic [DW-1:0]                            mem_wdata,
  input  logic [DW-1:0]                            mem_rdata,
  input  logic                                     mem_ack
);

  localparam int unsigned BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BYTE_SH = $clog2(DW / 8);
  localparam int unsigned OFF     = $clog2(BEATS) + BYTE_SH;
  localparam logic [BW-1:0] LAST  = BW'(BEATS - 1);
  localparam logic [AW-1:0] BASE_MASK = ~((AW'(1) << OFF) - AW'(1));

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_t;

  state_t        state;
  owner_t        owner;
  logic [AW-1:0] base_q;
  logic          we_q;
  logic [BW-1:0] beat_q;
  logic          grant_dc;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_dc = dc_req && (!ic_req || last_owner == OWN_IC);
  end
`else
  always_comb begin
    grant_dc = dc_req;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      owner  <= OWN_NONE;
      base_q <= '0;
      we_q   <= 1'b0;
      beat_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner <= OWN_IC;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ic_req || dc_req) begin
            state <= S_BUSY;
            if (grant_dc) begin
              owner  <= OWN_DC;
              base_q <= dc_addr & BASE_MASK;
              we_q   <= dc_we;
`ifdef MEM_ARB_RR_EN
              last_owner <= OWN_DC;
`endif
            end else begin
              owner  <= OWN_IC;
              base_q <= ic_addr & BASE_MASK;
              we_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
              last_owner <= OWN_IC;
`endif
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            if (beat_q == LAST) begin
              state  <= S_DONE;
              beat_q <= '0;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          owner <= OWN_NONE;
        end
        default: begin
          state <= S_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  logic busy;
  logic rd_beat;

  // Read data is forwarded in the ack cycle itself; everything else decodes registered state.
  always_comb begin
    busy      = (state == S_BUSY);
    rd_beat   = busy && mem_ack && !we_q;
    mem_req   = busy;
    mem_we    = busy && we_q;
    mem_addr  = busy ? (base_q + (AW'(beat_q) << BYTE_SH)) : '0;
    mem_wdata = (owner == OWN_DC) ? dc_wdata : '0;
    ic_rvalid = rd_beat && (owner == OWN_IC);
    dc_rvalid = rd_beat && (owner == OWN_DC);
    ic_rdata  = ic_rvalid ? mem_rdata : '0;
    dc_rdata  = dc_rvalid ? mem_rdata : '0;
    ic_done   = (state == S_DONE) && (owner == OWN_IC);
    dc_done   = (state == S_DONE) && (owner == OWN_DC);
    beat_idx  = beat_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected beats/dones, a monitor checks them.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ic_req, dc_req, dc_we;
  logic [31:0] ic_addr, dc_addr, dc_wdata;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        ic_rvalid, ic_done, dc_rvalid, dc_done;
  logic [1:0]  beat_idx;
  logic        mem_req, mem_we, mem_ack;

  mem_arbiter #(.AW(32), .DW(32), .BEATS(4)) dut (
    .CLK(CLK), .RST(RST),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .beat_idx(beat_idx), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  // Memory model returns an address-derived word; the D-cache supplies 0xA0+beat as write data.
  assign mem_rdata = 32'hD000_0000 ^ mem_addr;
  assign dc_wdata  = 32'hA0 + 32'(beat_idx);

  typedef struct {
    logic        is_dc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t exp_beats[$];
  logic  exp_dones[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int ack_mode = 0;
  int ack_cnt = 0;
  logic manual_ack = 1'b0;
  logic mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Ack source: 0 = always, 1 = every third cycle, 2 = driven by the stimulus process.
  always @(posedge CLK) begin
    #2;
    ack_cnt = ack_cnt + 1;
    if (ack_mode == 0)      mem_ack = 1'b1;
    else if (ack_mode == 1) mem_ack = (ack_cnt % 3 == 0);
    else                    mem_ack = manual_ack;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_burst(input logic is_dc, input logic we, input logic [31:0] addr,
                            input int nbeats, input logic with_done);
    beat_t b;
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF0;
    for (int i = 0; i < nbeats; i++) begin
      b.is_dc = is_dc;
      b.we    = we;
      b.addr  = base + 32'(4 * i);
      b.wdata = is_dc ? 32'hA0 + 32'(i) : 32'h0;
      exp_beats.push_back(b);
    end
    if (with_done) exp_dones.push_back(is_dc);
  endtask

  task automatic wait_done(input int limit, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge CLK); #1;
      if (ic_done || dc_done) begin
        done_cyc = cyc;
        return;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge CLK) begin
    if (!RST && mon_en) begin
      if (mem_req && mem_ack) begin
        if (exp_beats.size() == 0) begin
          chk("unexpected_beat", mem_addr, 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          logic  rd_ic, rd_dc;
          e = exp_beats.pop_front();
          rd_ic = !e.is_dc && !e.we;
          rd_dc = e.is_dc && !e.we;
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("ic_rvalid", 32'(ic_rvalid), 32'(rd_ic));
          chk("dc_rvalid", 32'(dc_rvalid), 32'(rd_dc));
          chk("ic_rdata", ic_rdata, rd_ic ? (32'hD000_0000 ^ e.addr) : 32'h0);
          chk("dc_rdata", dc_rdata, rd_dc ? (32'hD000_0000 ^ e.addr) : 32'h0);
        end
        last_ack_cyc = cyc;
      end else begin
        chk("rvalid_without_ack", {30'b0, ic_rvalid, dc_rvalid}, 32'h0);
      end
      if (mem_req && prev_req && !prev_ack) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_we", 32'(mem_we), 32'(prev_we));
        chk("hold_wdata", mem_wdata, prev_wdata);
      end
      if (ic_done || dc_done) begin
        chk("both_done", 32'(ic_done && dc_done), 32'h0);
        if (exp_dones.size() == 0) begin
          chk("unexpected_done", {30'b0, ic_done, dc_done}, 32'h0);
        end else begin
          logic d;
          d = exp_dones.pop_front();
          chk("done_owner_dc", 32'(dc_done), 32'(d));
          chk("done_after_last_ack", 32'(cyc), 32'(last_ack_cyc + 1));
        end
      end
    end
    prev_req   = mem_req;
    prev_ack   = mem_ack;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  int t_req, t_done;
  logic r2_dc;

  initial begin
    RST = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_beat_idx", 32'(beat_idx), 32'h0);
    chk("rst_rvalid", {30'b0, ic_rvalid, dc_rvalid}, 32'h0);
    chk("rst_done", {30'b0, ic_done, dc_done}, 32'h0);
    chk("rst_ic_rdata", ic_rdata, 32'h0);
    chk("rst_dc_rdata", dc_rdata, 32'h0);
    RST = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK); #1;

    // IC line read, ack held high
    push_burst(1'b0, 1'b0, 32'h0000_1034, 4, 1'b1);
    ic_addr = 32'h0000_1034; ic_req = 1'b1; t_req = cyc;
    @(posedge CLK); #1;
    chk("req_latency", 32'(mem_req), 32'h1);
    wait_done(20, t_done);
    ic_req = 1'b0;
    chk("ic_total_latency", 32'(t_done - t_req), 32'd5);
    repeat (2) @(posedge CLK);
    #1;

    // DC write-back
    push_burst(1'b1, 1'b1, 32'h0000_2000, 4, 1'b1);
    dc_addr = 32'h0000_2000; dc_we = 1'b1; dc_req = 1'b1;
    wait_done(20, t_done);
    dc_req = 1'b0; dc_we = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // IC read with sparse acks
    ack_mode = 1;
    push_burst(1'b0, 1'b0, 32'h0000_4008, 4, 1'b1);
    ic_addr = 32'h0000_4008; ic_req = 1'b1;
    wait_done(40, t_done);
    ic_req = 1'b0;
    ack_mode = 0;
    repeat (2) @(posedge CLK);
    #1;

    // Simultaneous requests held across rounds
`ifdef MEM_ARB_RR_EN
    r2_dc = 1'b0;
`else
    r2_dc = 1'b1;
`endif
    push_burst(1'b1, 1'b0, 32'h0000_6000, 4, 1'b1);
    push_burst(r2_dc, 1'b0, r2_dc ? 32'h0000_6000 : 32'h0000_7014, 4, 1'b1);
    push_burst(!r2_dc, 1'b0, r2_dc ? 32'h0000_7014 : 32'h0000_6000, 4, 1'b1);
    ic_addr = 32'h0000_7014; dc_addr = 32'h0000_6000; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    wait_done(20, t_done);
    wait_done(20, t_done);
    if (r2_dc) dc_req = 1'b0; else ic_req = 1'b0;
    wait_done(20, t_done);
    ic_req = 1'b0; dc_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset after two acks abandons the burst
    ack_mode = 2;
    push_burst(1'b0, 1'b0, 32'h0000_8000, 2, 1'b0);
    ic_addr = 32'h0000_8000; ic_req = 1'b1; manual_ack = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    manual_ack = 1'b0; ic_req = 1'b0; RST = 1'b1; mon_en = 1'b0;
    @(posedge CLK); #1;
    chk("abort_mem_req", 32'(mem_req), 32'h0);
    chk("abort_beat_idx", 32'(beat_idx), 32'h0);
    chk("abort_no_done", {30'b0, ic_done, dc_done}, 32'h0);
    chk("abort_beats_seen", 32'(exp_beats.size()), 32'h0);
    RST = 1'b0; mon_en = 1'b1; ack_mode = 0;
    @(posedge CLK); #1;
    chk("abort_idle_after", 32'(mem_req), 32'h0);
    push_burst(1'b0, 1'b0, 32'h0000_8000, 4, 1'b1);
    ic_req = 1'b1;
    wait_done(20, t_done);
    ic_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // DC drops request and changes address after the first ack
    push_burst(1'b1, 1'b0, 32'h0000_3000, 4, 1'b1);
    dc_addr = 32'h0000_3000; dc_we = 1'b0; dc_req = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    dc_req = 1'b0; dc_addr = 32'h0000_5550;
    wait_done(20, t_done);
    repeat (6) @(posedge CLK);
    #1;
    chk("beats_left", 32'(exp_beats.size()), 32'h0);
    chk("dones_left", 32'(exp_dones.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
